// File: rtl/hdmi_text_axi_pkg.sv
// Shared types for the text-mode VRAM/palette AXI4-Lite bridge: FSM states, response codes, region decode.
package hdmi_text_axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ACC,
    B_RESP,
    AR_ACC,
    RD_WAIT,
    R_RESP
  } state_t;

  typedef enum logic [1:0] {
    VRAM,
    PAL,
    MISS
  } region_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Word index -> target; the hole between VRAM and the palette decodes as a miss.
  function automatic region_t decode_region(input logic [31:0] idx,
                                            input int unsigned vram_words,
                                            input int unsigned pal_base,
                                            input int unsigned pal_regs);
    if (idx < vram_words)
      return VRAM;
    else if (idx >= pal_base && idx < pal_base + pal_regs)
      return PAL;
    else
      return MISS;
  endfunction

endpackage

// File: rtl/hdmi_text_axi_palette.sv
// Palette register file: byte-strobed write, one cycle after wr_en; combinational read mux.
// No backpressure; the bridge FSM guarantees one access at a time.
module hdmi_text_axi_palette
  import hdmi_text_axi_pkg::*;
#(
  parameter int unsigned REGS  = 8,
  parameter int          SEL_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [SEL_W-1:0]     wr_sel,
  input  logic [3:0]           wr_strb,
  input  logic [31:0]          wr_data,
  input  logic [SEL_W-1:0]     rd_sel,
  output logic [31:0]          rd_data,
  output logic [REGS*32-1:0]   regs_flat
);

  logic [31:0] regs [REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++)
        if (wr_strb[b]) regs[wr_sel][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
  end

  assign rd_data = regs[rd_sel];

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < REGS; i++) regs_flat[i*32 +: 32] = regs[i];
  end

endmodule

// File: rtl/hdmi_text_axi_vram_bridge.sv
// AXI4-Lite slave to VRAM port A + palette; write B at grant+2, read R at grant+2+BRAM_RD_LATENCY.
// One transaction in flight, READY only in *_ACC states; HDMI_AXI_SLVERR_EN makes decode misses return SLVERR.
module hdmi_text_axi_vram_bridge
  import hdmi_text_axi_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 16,
  parameter int unsigned VRAM_WORDS         = 1200,
  parameter int unsigned PAL_BASE_WORD      = 2048,
  parameter int unsigned PALETTE_REGS       = 8,
  parameter int          BRAM_RD_LATENCY    = 2
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              bram_en,
  output logic [3:0]                        bram_we,
  output logic [$clog2(VRAM_WORDS)-1:0]     bram_addr,
  output logic [31:0]                       bram_din,
  input  logic [31:0]                       bram_dout,
  output logic [PALETTE_REGS*32-1:0]        palette_o
);

  localparam int         BRAM_AW   = $clog2(VRAM_WORDS);
  localparam int         IDX_W     = C_S_AXI_ADDR_WIDTH - 2;
  localparam int         PAL_SEL_W = (PALETTE_REGS > 1) ? $clog2(PALETTE_REGS) : 1;
  localparam logic [2:0] LAT_LAST  = 3'(BRAM_RD_LATENCY - 1);

`ifdef HDMI_AXI_SLVERR_EN
  localparam logic [1:0] MISS_RESP = RESP_SLVERR;
`else
  localparam logic [1:0] MISS_RESP = RESP_OKAY;
`endif

  if (C_S_AXI_DATA_WIDTH != 32) begin : g_dw_check
    $error("hdmi_text_axi_vram_bridge supports a 32-bit data bus only");
  end
  if (BRAM_RD_LATENCY < 1 || BRAM_RD_LATENCY > 4) begin : g_lat_check
    $error("BRAM_RD_LATENCY must be 1..4");
  end
  if (PAL_BASE_WORD < VRAM_WORDS) begin : g_map_check
    $error("palette must sit above VRAM");
  end

  state_t                 state, next_state;
  logic                   last_grant_wr;
  logic                   wr_pend, rd_pend, grant_wr, grant_rd;
  logic [IDX_W-1:0]       aw_idx, ar_idx;
  region_t                aw_region, ar_region, cur_region;
  logic [PAL_SEL_W-1:0]   aw_pal_sel, ar_pal_sel, cur_pal_sel;
  logic [3:0]             cur_strb;
  logic [31:0]            cur_wdata;
  logic [2:0]             lat_cnt;
  logic [31:0]            pal_rd_data;
  logic [31:0]            rdata_q;
  logic [1:0]             bresp_q, rresp_q;
  logic                   unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign aw_idx     = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign ar_idx     = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign aw_region  = decode_region(32'(aw_idx), VRAM_WORDS, PAL_BASE_WORD, PALETTE_REGS);
  assign ar_region  = decode_region(32'(ar_idx), VRAM_WORDS, PAL_BASE_WORD, PALETTE_REGS);
  assign aw_pal_sel = PAL_SEL_W'(32'(aw_idx) - PAL_BASE_WORD);
  assign ar_pal_sel = PAL_SEL_W'(32'(ar_idx) - PAL_BASE_WORD);

  // A write needs both AW and W; on contention the type not served last time wins.
  assign wr_pend  = S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_pend  = S_AXI_ARVALID;
  assign grant_wr = wr_pend && (!rd_pend || !last_grant_wr);
  assign grant_rd = rd_pend && !grant_wr;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) state <= IDLE;
    else              state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant_wr)      next_state = WR_ACC;
               else if (grant_rd) next_state = AR_ACC;
      WR_ACC:  next_state = B_RESP;
      B_RESP:  if (S_AXI_BREADY)  next_state = IDLE;
      AR_ACC:  next_state = RD_WAIT;
      RD_WAIT: if (lat_cnt == LAT_LAST) next_state = R_RESP;
      R_RESP:  if (S_AXI_RREADY)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_ARREADY = 1'b0;
    S_AXI_BVALID  = 1'b0;
    S_AXI_RVALID  = 1'b0;
    case (state)
      WR_ACC: begin
        S_AXI_AWREADY = 1'b1;
        S_AXI_WREADY  = 1'b1;
      end
      AR_ACC: S_AXI_ARREADY = 1'b1;
      B_RESP: S_AXI_BVALID  = 1'b1;
      R_RESP: S_AXI_RVALID  = 1'b1;
      default: ;
    endcase
  end

  assign S_AXI_BRESP = bresp_q;
  assign S_AXI_RRESP = rresp_q;
  assign S_AXI_RDATA = rdata_q;

  // Bus fields are captured on the grant edge so the BRAM pulse lines up with the *_ACC cycle.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      last_grant_wr <= 1'b0;
      cur_region    <= VRAM;
      cur_pal_sel   <= '0;
      cur_strb      <= '0;
      cur_wdata     <= '0;
      lat_cnt       <= '0;
      rdata_q       <= '0;
      bresp_q       <= RESP_OKAY;
      rresp_q       <= RESP_OKAY;
      bram_en       <= 1'b0;
      bram_we       <= '0;
      bram_addr     <= '0;
      bram_din      <= '0;
    end else begin
      bram_en <= 1'b0;
      bram_we <= '0;
      case (state)
        IDLE: begin
          if (grant_wr) begin
            last_grant_wr <= 1'b1;
            cur_region    <= aw_region;
            cur_pal_sel   <= aw_pal_sel;
            cur_strb      <= S_AXI_WSTRB;
            cur_wdata     <= S_AXI_WDATA;
            if (aw_region == VRAM) begin
              bram_en   <= 1'b1;
              bram_we   <= S_AXI_WSTRB;
              bram_addr <= BRAM_AW'(aw_idx);
              bram_din  <= S_AXI_WDATA;
            end
          end else if (grant_rd) begin
            last_grant_wr <= 1'b0;
            cur_region    <= ar_region;
            cur_pal_sel   <= ar_pal_sel;
            if (ar_region == VRAM) begin
              bram_en   <= 1'b1;
              bram_addr <= BRAM_AW'(ar_idx);
            end
          end
        end
        WR_ACC:  bresp_q <= (cur_region == MISS) ? MISS_RESP : RESP_OKAY;
        AR_ACC:  lat_cnt <= '0;
        RD_WAIT: begin
          lat_cnt <= lat_cnt + 3'd1;
          if (lat_cnt == LAT_LAST) begin
            case (cur_region)
              VRAM:    rdata_q <= bram_dout;
              PAL:     rdata_q <= pal_rd_data;
              default: rdata_q <= '0;
            endcase
            rresp_q <= (cur_region == MISS) ? MISS_RESP : RESP_OKAY;
          end
        end
        default: ;
      endcase
    end
  end

  hdmi_text_axi_palette #(
    .REGS  (PALETTE_REGS),
    .SEL_W (PAL_SEL_W)
  ) u_palette (
    .clk       (S_AXI_ACLK),
    .rst       (S_AXI_ARESET),
    .wr_en     (state == WR_ACC && cur_region == PAL),
    .wr_sel    (cur_pal_sel),
    .wr_strb   (cur_strb),
    .wr_data   (cur_wdata),
    .rd_sel    (cur_pal_sel),
    .rd_data   (pal_rd_data),
    .regs_flat (palette_o)
  );

endmodule

// File: tb/tb_hdmi_text_axi_vram_bridge.sv
// Bench for hdmi_text_axi_vram_bridge: vector table through a response scoreboard plus arbitration/reset sequences.
module tb_hdmi_text_axi_vram_bridge;

`ifdef HDMI_AXI_SLVERR_EN
  localparam logic [1:0] MISS_RESP = 2'b10;
`else
  localparam logic [1:0] MISS_RESP = 2'b00;
`endif
  localparam logic [1:0] OK = 2'b00;
  localparam int RD_LAT = 2 + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic         bram_en;
  logic [3:0]   bram_we;
  logic [10:0]  bram_addr;
  logic [31:0]  bram_din, bram_dout;
  logic [255:0] palette;

  always #5 clk = ~clk;

  hdmi_text_axi_vram_bridge dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .bram_dout(bram_dout), .palette_o(palette)
  );

  // Two-stage read pipeline models a latency-2 BRAM port.
  logic [31:0] mem [0:2047];
  logic [31:0] pipe1, pipe2;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2048; i++) mem[i] <= '0;
      pipe1 <= '0;
      pipe2 <= '0;
    end else begin
      if (bram_en) begin
        for (int b = 0; b < 4; b++)
          if (bram_we[b]) mem[bram_addr][b*8 +: 8] <= bram_din[b*8 +: 8];
        pipe1 <= mem[bram_addr];
      end
      pipe2 <= pipe1;
    end
  end
  assign bram_dout = pipe2;

  typedef struct { logic [31:0] data; logic [1:0] resp; int lat; } exp_t;
  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: no response within 20 cycles", name);
    if (sb.size() > 0) void'(sb.pop_front());
  endtask

  task automatic do_write(input string tag, input logic [15:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] exp_resp, input int exp_en);
    exp_t e;
    int n = 0, en_cnt = 0;
    bit hs = 0, done = 0;
    logic [3:0] we_seen = '0;
    logic [10:0] addr_seen = '0;
    e.data = '0; e.resp = exp_resp; e.lat = 2;
    sb.push_back(e);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    while (!done && n < 20) begin
      @(negedge clk); n++;
      if (hs) begin awvalid = 1'b0; wvalid = 1'b0; end
      if (bram_en) begin en_cnt++; we_seen = bram_we; addr_seen = bram_addr; end
      if (awready && wready) hs = 1;
      if (bvalid) begin
        e = sb.pop_front();
        check({tag, "_bresp"}, 32'(bresp), 32'(e.resp));
        check({tag, "_blat"}, n, e.lat);
        done = 1;
      end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!done) timeout({tag, "_b"});
    check({tag, "_en_pulses"}, en_cnt, exp_en);
    if (exp_en != 0) begin
      check({tag, "_we"}, 32'(we_seen), 32'(strb));
      check({tag, "_addr"}, 32'(addr_seen), 32'(addr[12:2]));
    end
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [15:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input int exp_en);
    exp_t e;
    int n = 0, en_cnt = 0, we_bad = 0;
    bit hs = 0, done = 0;
    logic [10:0] addr_seen = '0;
    e.data = exp_data; e.resp = exp_resp; e.lat = RD_LAT;
    sb.push_back(e);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    while (!done && n < 20) begin
      @(negedge clk); n++;
      if (hs) arvalid = 1'b0;
      if (bram_en) begin en_cnt++; addr_seen = bram_addr; end
      if (bram_we != 4'h0) we_bad++;
      if (arready) hs = 1;
      if (rvalid) begin
        e = sb.pop_front();
        check({tag, "_rdata"}, rdata, e.data);
        check({tag, "_rresp"}, 32'(rresp), 32'(e.resp));
        check({tag, "_rlat"}, n, e.lat);
        done = 1;
      end
    end
    arvalid = 1'b0;
    if (!done) timeout({tag, "_r"});
    check({tag, "_en_pulses"}, en_cnt, exp_en);
    check({tag, "_we_during_read"}, we_bad, 0);
    if (exp_en != 0) check({tag, "_addr"}, 32'(addr_seen), 32'(addr[12:2]));
    @(negedge clk);
    rready = 1'b0;
  endtask

  typedef struct {
    bit          is_wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          en;
  } vec_t;

  vec_t vecs[18];
  logic [7:0] order[$];
  logic [7:0] rr_exp[4];
  int rv_cnt;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 16'h0014, 32'hDEADBEEF, 4'hF, 32'h0,        OK,        1};
    vecs[1]  = '{1'b0, 16'h0014, 32'h0,        4'h0, 32'hDEADBEEF, OK,        1};
    vecs[2]  = '{1'b1, 16'h0018, 32'hCAFEF00D, 4'h5, 32'h0,        OK,        1};
    vecs[3]  = '{1'b0, 16'h0018, 32'h0,        4'h0, 32'h00FE000D, OK,        1};
    vecs[4]  = '{1'b1, 16'h001C, 32'h12345678, 4'h0, 32'h0,        OK,        1};
    vecs[5]  = '{1'b0, 16'h001C, 32'h0,        4'h0, 32'h0,        OK,        1};
    vecs[6]  = '{1'b1, 16'h2004, 32'h11223344, 4'hF, 32'h0,        OK,        0};
    vecs[7]  = '{1'b1, 16'h2004, 32'h000000AB, 4'h1, 32'h0,        OK,        0};
    vecs[8]  = '{1'b0, 16'h2004, 32'h0,        4'h0, 32'h112233AB, OK,        0};
    vecs[9]  = '{1'b0, 16'h1770, 32'h0,        4'h0, 32'h0,        MISS_RESP, 0};
    vecs[10] = '{1'b1, 16'h1770, 32'h55555555, 4'hF, 32'h0,        MISS_RESP, 0};
    vecs[11] = '{1'b0, 16'h2020, 32'h0,        4'h0, 32'h0,        MISS_RESP, 0};
    vecs[12] = '{1'b1, 16'h12BC, 32'hA5A5A5A5, 4'hF, 32'h0,        OK,        1};
    vecs[13] = '{1'b0, 16'h12BC, 32'h0,        4'h0, 32'hA5A5A5A5, OK,        1};
    vecs[14] = '{1'b0, 16'h12C0, 32'h0,        4'h0, 32'h0,        MISS_RESP, 0};
    vecs[15] = '{1'b1, 16'h201C, 32'h0F0F0F0F, 4'hF, 32'h0,        OK,        0};
    vecs[16] = '{1'b0, 16'h201C, 32'h0,        4'h0, 32'h0F0F0F0F, OK,        0};
    vecs[17] = '{1'b0, 16'h2007, 32'h0,        4'h0, 32'h112233AB, OK,        0};
    rr_exp[0] = "W"; rr_exp[1] = "R"; rr_exp[2] = "W"; rr_exp[3] = "R";

    rst = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    wdata = '0; wstrb = '0;
    repeat (3) @(negedge clk);
    check("rst_ready_valid", 32'({awready, wready, arready, bvalid, rvalid}), 32'h0);
    check("rst_resp", 32'({bresp, rresp}), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_bram_ctl", 32'({bram_en, bram_we, bram_addr}), 32'h0);
    check("rst_bram_din", bram_din, 32'h0);
    check("rst_palette", 32'(|palette), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      if (vecs[i].is_wr)
        do_write($sformatf("v%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].resp, vecs[i].en);
      else
        do_read($sformatf("v%0d", i), vecs[i].addr, vecs[i].rdata, vecs[i].resp, vecs[i].en);
    end
    check("pal_reg1", palette[63:32], 32'h112233AB);
    check("pal_reg7", palette[255:224], 32'h0F0F0F0F);
    check("pal_reg0", palette[31:0], 32'h0);

    // Simultaneous AW/W and AR held high: grants must alternate, starting with the write.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    awaddr = 16'h0020; wdata = 32'h13579BDF; wstrb = 4'hF; araddr = 16'h0014;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (awready) order.push_back("W");
      if (arready) order.push_back("R");
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    repeat (8) @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    for (int i = 0; i < 4; i++)
      check($sformatf("rr_grant%0d", i), 32'((i < order.size()) ? order[i] : 8'h00), 32'(rr_exp[i]));

    // Reset while a read waits on BRAM, with RREADY low: the read must vanish.
    @(negedge clk);
    araddr = 16'h0014; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rvalid", 32'(rvalid), 32'h0);
    check("midrst_ready", 32'({arready, awready, bram_en}), 32'h0);
    check("midrst_palette", 32'(|palette), 32'h0);
    rst = 1'b0;
    rv_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (rvalid) rv_cnt++;
    end
    check("midrst_no_stale_r", rv_cnt, 0);
    do_write("postrst_w", 16'h0024, 32'h600DF00D, 4'hF, OK, 1);
    do_read("postrst_r", 16'h0024, 32'h600DF00D, OK, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
